// File: rtl/ccc_lock_sequencer.sv
// ---------------------------------------------------------------------------
// ccc_lock_sequencer
//
// Purpose:
//   Qualifies the raw CCC PLL lock and sequences up to four per-domain resets.
//   LOCK_IN is synchronised, then filtered: it must stay high for LOCK_FILT
//   consecutive cycles before LOCKED is declared. The domain resets are then
//   released one by one, SEQ_GAP cycles apart, channel 0 first. Each released
//   domain gets a divided clock-enable. Losing lock at any point after
//   qualification reasserts every reset and restarts the whole procedure.
//
// Ports:
//   CLK            fabric clock (CCC GL output)
//   ARST           asynchronous, active-high reset
//   LOCK_IN        raw CCC LOCK, asynchronous to CLK
//   CH_EN          per-channel enable
//   DIV            per-channel divide-minus-one, channel k at [k*DIV_W +: DIV_W]
//   RST_OUT        per-domain active-high reset
//   CE_OUT         per-domain clock-enable
//   LOCKED         qualified lock
//   LOCK_LOSS_CNT  saturating count of lock-loss events
//
// Configuration macro:
//   CCC_SEQ_LOSS_CNT_EN  when defined, the 8-bit saturating lock-loss counter
//                        is built; otherwise LOCK_LOSS_CNT is tied to 8'h00.
// ---------------------------------------------------------------------------
module ccc_lock_sequencer #(
  parameter int NUM_CH    = 4,
  parameter int LOCK_FILT = 16,
  parameter int SEQ_GAP   = 4,
  parameter int DIV_W     = 4
) (
  input  logic                      CLK,
  input  logic                      ARST,
  input  logic                      LOCK_IN,
  input  logic [NUM_CH-1:0]         CH_EN,
  input  logic [NUM_CH*DIV_W-1:0]   DIV,
  output logic [NUM_CH-1:0]         RST_OUT,
  output logic [NUM_CH-1:0]         CE_OUT,
  output logic                      LOCKED,
  output logic [7:0]                LOCK_LOSS_CNT
);

  localparam int FILT_W = $clog2(LOCK_FILT + 1);
  localparam int SLOT_W = (SEQ_GAP > 1) ? $clog2(SEQ_GAP) : 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SEQ       = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t              state;
  logic                lock_meta;
  logic                lock_s;
  logic [FILT_W-1:0]   filt_cnt;
  logic [SLOT_W-1:0]   slot_cnt;
  logic [CH_W-1:0]     ch_idx;
  logic                loss;
  logic                slot_end;
  logic [NUM_CH-1:0]   rst_next;
  logic [DIV_W-1:0]    div_cnt [NUM_CH];
  logic [DIV_W-1:0]    div_cap [NUM_CH];

  // Two-flop synchroniser bringing the asynchronous PLL lock into CLK.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= LOCK_IN;
      lock_s    <= lock_meta;
    end
  end

  // Next value of every domain reset. Lock loss and a disabled channel both
  // force the reset on, and both win over a release at the end of a slot.
  // In WAIT_LOCK every reset is already high, so forcing it there is harmless.
  always_comb begin
    loss     = (state != WAIT_LOCK) && !lock_s;
    slot_end = (state == SEQ) && (slot_cnt == SLOT_W'(SEQ_GAP - 1));
    rst_next = RST_OUT;
    for (int k = 0; k < NUM_CH; k++) begin
      if (loss || !CH_EN[k]) begin
        rst_next[k] = 1'b1;
      end else if (slot_end && (ch_idx == CH_W'(k))) begin
        rst_next[k] = 1'b0;
      end
    end
  end

  // Main sequencer: lock filter, staggered release slots and the run state.
  // The filter only declares lock on the cycle after it has counted LOCK_FILT
  // high samples, so LOCKED appears LOCK_FILT+2 edges after the first high
  // sample of LOCK_IN.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state    <= WAIT_LOCK;
      filt_cnt <= '0;
      slot_cnt <= '0;
      ch_idx   <= '0;
      LOCKED   <= 1'b0;
      RST_OUT  <= '1;
    end else begin
      RST_OUT <= rst_next;
      case (state)
        WAIT_LOCK: begin
          if (!lock_s) begin
            filt_cnt <= '0;
          end else if (filt_cnt == FILT_W'(LOCK_FILT)) begin
            state    <= SEQ;
            LOCKED   <= 1'b1;
            filt_cnt <= '0;
            slot_cnt <= '0;
            ch_idx   <= '0;
          end else begin
            filt_cnt <= filt_cnt + FILT_W'(1);
          end
        end
        SEQ: begin
          if (loss) begin
            state    <= WAIT_LOCK;
            LOCKED   <= 1'b0;
            filt_cnt <= '0;
          end else if (slot_end) begin
            slot_cnt <= '0;
            if (ch_idx == CH_W'(NUM_CH - 1)) begin
              state <= RUN;
            end else begin
              ch_idx <= ch_idx + CH_W'(1);
            end
          end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
          end
        end
        RUN: begin
          if (loss) begin
            state    <= WAIT_LOCK;
            LOCKED   <= 1'b0;
            filt_cnt <= '0;
          end
        end
        default: begin
          state    <= WAIT_LOCK;
          LOCKED   <= 1'b0;
          filt_cnt <= '0;
        end
      endcase
    end
  end

  // Per-channel clock-enable dividers. The enable is computed from the reset
  // value being loaded on this same edge, so CE_OUT drops together with any
  // reassertion of RST_OUT. The ratio is latched at release and at every wrap,
  // which makes a mid-period DIV change take effect only after the current
  // period has finished.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      CE_OUT <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        div_cnt[k] <= '0;
        div_cap[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (rst_next[k]) begin
          div_cnt[k] <= '0;
          CE_OUT[k]  <= 1'b0;
        end else if (RST_OUT[k]) begin
          div_cnt[k] <= '0;
          div_cap[k] <= DIV[k*DIV_W +: DIV_W];
          CE_OUT[k]  <= 1'b0;
        end else if (div_cnt[k] == div_cap[k]) begin
          div_cnt[k] <= '0;
          div_cap[k] <= DIV[k*DIV_W +: DIV_W];
          CE_OUT[k]  <= 1'b1;
        end else begin
          div_cnt[k] <= div_cnt[k] + DIV_W'(1);
          CE_OUT[k]  <= 1'b0;
        end
      end
    end
  end

`ifdef CCC_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;

  // Saturating count of lock losses seen after lock had been qualified.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      loss_cnt <= 8'h00;
    end else if (loss && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign LOCK_LOSS_CNT = loss_cnt;
`else
  assign LOCK_LOSS_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_ccc_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ccc_lock_sequencer
//
// Directed and randomised stimulus for ccc_lock_sequencer (NUM_CH=3,
// LOCK_FILT=16, SEQ_GAP=4, DIV_W=4). A reference model works in absolute
// edge numbers: it remembers the edge at which lock was declared and derives
// release edges and clock-enable pulse edges arithmetically from it.
// ---------------------------------------------------------------------------
module tb_ccc_lock_sequencer;

  localparam int NUM_CH    = 3;
  localparam int LOCK_FILT = 16;
  localparam int SEQ_GAP   = 4;
  localparam int DIV_W     = 4;

  logic                    clk = 1'b0;
  logic                    arst;
  logic                    lock_in;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*DIV_W-1:0] div;
  logic [NUM_CH-1:0]       rst_out;
  logic [NUM_CH-1:0]       ce_out;
  logic                    locked;
  logic [7:0]              lock_loss_cnt;

  int compared   = 0;
  int mismatched = 0;
  int edge_no    = 0;

  bit                m_s1;
  bit                m_s2;
  bit                m_locked;
  int                m_streak;
  int                m_lock_edge;
  int                m_loss;
  logic [NUM_CH-1:0] m_rst;
  logic [NUM_CH-1:0] m_ce;
  int                m_next [NUM_CH];

  ccc_lock_sequencer #(
    .NUM_CH   (NUM_CH),
    .LOCK_FILT(LOCK_FILT),
    .SEQ_GAP  (SEQ_GAP),
    .DIV_W    (DIV_W)
  ) dut (
    .CLK          (clk),
    .ARST         (arst),
    .LOCK_IN      (lock_in),
    .CH_EN        (ch_en),
    .DIV          (div),
    .RST_OUT      (rst_out),
    .CE_OUT       (ce_out),
    .LOCKED       (locked),
    .LOCK_LOSS_CNT(lock_loss_cnt)
  );

  // Free-running 100 MHz fabric clock.
  always #5 clk = ~clk;

  function automatic int divOf(input int k);
    return int'(div[k*DIV_W +: DIV_W]);
  endfunction

  function automatic int expLossCnt();
`ifdef CCC_SEQ_LOSS_CNT_EN
    return m_loss;
`else
    return 0;
`endif
  endfunction

  task automatic modelReset();
    m_s1      = 1'b0;
    m_s2      = 1'b0;
    m_locked  = 1'b0;
    m_streak  = 0;
    m_loss    = 0;
    m_rst     = '1;
    m_ce      = '0;
    for (int k = 0; k < NUM_CH; k++) m_next[k] = 0;
  endtask

  task automatic modelStep();
    logic              lsv;
    logic [NUM_CH-1:0] just_rel;
    lsv      = m_s2;
    m_s2     = m_s1;
    m_s1     = lock_in;
    just_rel = '0;
    if (!m_locked) begin
      if (lsv) begin
        m_streak++;
        if (m_streak == LOCK_FILT + 1) begin
          m_locked    = 1'b1;
          m_lock_edge = edge_no;
        end
      end else begin
        m_streak = 0;
      end
    end else if (!lsv) begin
      m_locked = 1'b0;
      m_streak = 0;
      m_rst    = '1;
      m_ce     = '0;
      if (m_loss < 255) m_loss++;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!ch_en[k]) begin
          m_rst[k] = 1'b1;
        end else if (edge_no == m_lock_edge + (k + 1) * SEQ_GAP) begin
          m_rst[k]    = 1'b0;
          just_rel[k] = 1'b1;
          m_next[k]   = edge_no + divOf(k) + 1;
        end
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (m_rst[k] || just_rel[k]) begin
          m_ce[k] = 1'b0;
        end else if (edge_no == m_next[k]) begin
          m_ce[k]   = 1'b1;
          m_next[k] = edge_no + divOf(k) + 1;
        end else begin
          m_ce[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_rst"},    32'(rst_out),       32'(m_rst));
    checkOutput({tag, "_ce"},     32'(ce_out),        32'(m_ce));
    checkOutput({tag, "_locked"}, 32'(locked),        32'(m_locked));
    checkOutput({tag, "_cnt"},    32'(lock_loss_cnt), 32'(expLossCnt()));
  endtask

  task automatic applyStimulus(input logic l, input logic [NUM_CH-1:0] en,
                               input logic [NUM_CH*DIV_W-1:0] d);
    lock_in = l;
    ch_en   = en;
    div     = d;
    @(posedge clk);
    edge_no++;
    modelStep();
    #1;
    checkModel("model");
  endtask

  task automatic doReset(input int cycles);
    arst = 1'b1;
    modelReset();
    #1;
    checkOutput("arst_rst",    32'(rst_out),       32'h7);
    checkOutput("arst_ce",     32'(ce_out),        32'h0);
    checkOutput("arst_locked", 32'(locked),        32'h0);
    checkOutput("arst_cnt",    32'(lock_loss_cnt), 32'h0);
    repeat (cycles) @(posedge clk);
    #1;
    checkModel("in_reset");
    arst = 1'b0;
  endtask

  initial begin
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*DIV_W-1:0] d;
    int                      hi;
    int                      lo;

    arst    = 1'b1;
    lock_in = 1'b0;
    ch_en   = 3'b111;
    div     = '0;
    doReset(3);
    repeat (4) applyStimulus(1'b0, 3'b111, 12'h000);

    // Clean lock.
    for (int i = 0; i <= 34; i++) begin
      applyStimulus(1'b1, 3'b111, 12'h000);
      if (i == 17) checkOutput("clean_locked17", 32'(locked), 32'h0);
      if (i == 18) checkOutput("clean_locked18", 32'(locked), 32'h1);
      if (i == 21) checkOutput("clean_rst21", 32'(rst_out), 32'h7);
      if (i == 22) checkOutput("clean_rst22", 32'(rst_out), 32'h6);
      if (i == 25) checkOutput("clean_rst25", 32'(rst_out), 32'h6);
      if (i == 26) checkOutput("clean_rst26", 32'(rst_out), 32'h4);
      if (i == 30) checkOutput("clean_rst30", 32'(rst_out), 32'h0);
      if (i == 30) checkOutput("clean_ce30", 32'(ce_out), 32'h3);
      if (i == 31) checkOutput("clean_ce31", 32'(ce_out), 32'h7);
    end

    // Lock loss in RUN.
    for (int j = 0; j < 5; j++) begin
      applyStimulus(1'b0, 3'b111, 12'h000);
      if (j == 1) checkOutput("loss_rst1", 32'(rst_out), 32'h0);
      if (j == 1) checkOutput("loss_locked1", 32'(locked), 32'h1);
      if (j == 2) checkOutput("loss_rst2", 32'(rst_out), 32'h7);
      if (j == 2) checkOutput("loss_locked2", 32'(locked), 32'h0);
`ifdef CCC_SEQ_LOSS_CNT_EN
      if (j == 2) checkOutput("loss_cnt2", 32'(lock_loss_cnt), 32'h1);
`else
      if (j == 2) checkOutput("loss_cnt2", 32'(lock_loss_cnt), 32'h0);
`endif
    end

    // Glitch filter: one low sample restarts qualification.
    for (int i = 0; i <= 31; i++) begin
      applyStimulus((i == 10) ? 1'b0 : 1'b1, 3'b111, 12'h000);
      if (i == 28) checkOutput("glitch_locked28", 32'(locked), 32'h0);
      if (i == 29) checkOutput("glitch_locked29", 32'(locked), 32'h1);
    end
    repeat (4) applyStimulus(1'b0, 3'b111, 12'h000);

    // Divider on channel 0, ratio change mid-period.
    for (int i = 0; i <= 40; i++) begin
      applyStimulus(1'b1, 3'b111, (i >= 31) ? 12'h001 : 12'h003);
      if (i == 25) checkOutput("div_ce25", 32'(ce_out[0]), 32'h0);
      if (i == 26) checkOutput("div_ce26", 32'(ce_out[0]), 32'h1);
      if (i == 27) checkOutput("div_ce27", 32'(ce_out[0]), 32'h0);
      if (i == 29) checkOutput("div_ce29", 32'(ce_out[0]), 32'h0);
      if (i == 30) checkOutput("div_ce30", 32'(ce_out[0]), 32'h1);
      if (i == 33) checkOutput("div_ce33", 32'(ce_out[0]), 32'h0);
      if (i == 34) checkOutput("div_ce34", 32'(ce_out[0]), 32'h1);
      if (i == 35) checkOutput("div_ce35", 32'(ce_out[0]), 32'h0);
      if (i == 36) checkOutput("div_ce36", 32'(ce_out[0]), 32'h1);
      if (i == 37) checkOutput("div_ce37", 32'(ce_out[0]), 32'h0);
      if (i == 38) checkOutput("div_ce38", 32'(ce_out[0]), 32'h1);
    end
    repeat (4) applyStimulus(1'b0, 3'b111, 12'h000);

    // Channel disable before the slot and during RUN.
    for (int i = 0; i <= 36; i++) begin
      applyStimulus(1'b1, (i >= 35) ? 3'b100 : 3'b101, 12'h000);
      if (i == 26) checkOutput("dis_rst26", 32'(rst_out), 32'h6);
      if (i == 30) checkOutput("dis_rst30", 32'(rst_out), 32'h2);
      if (i == 35) checkOutput("dis_rst35", 32'(rst_out), 32'h3);
      if (i == 35) checkOutput("dis_ce35", 32'(ce_out[0]), 32'h0);
    end
    repeat (4) applyStimulus(1'b0, 3'b111, 12'h000);

    // Reset in the middle of the release sequence, then a full restart.
    for (int i = 0; i <= 24; i++) applyStimulus(1'b1, 3'b111, 12'h000);
    doReset(2);
    for (int i = 0; i <= 31; i++) begin
      applyStimulus(1'b1, 3'b111, 12'h000);
      if (i == 17) checkOutput("rerun_locked17", 32'(locked), 32'h0);
      if (i == 18) checkOutput("rerun_locked18", 32'(locked), 32'h1);
      if (i == 22) checkOutput("rerun_rst22", 32'(rst_out), 32'h6);
      if (i == 30) checkOutput("rerun_rst30", 32'(rst_out), 32'h0);
    end

    // Repeated lock/unlock episodes drive the counter into saturation.
    for (int n = 0; n < 300; n++) begin
      hi = $urandom_range(17, 24);
      lo = $urandom_range(1, 3);
      d  = 12'($urandom);
      for (int c = 0; c < hi; c++) applyStimulus(1'b1, 3'b111, d);
      for (int c = 0; c < lo; c++) applyStimulus(1'b0, 3'b111, d);
    end
    repeat (3) applyStimulus(1'b0, 3'b111, 12'h000);
`ifdef CCC_SEQ_LOSS_CNT_EN
    checkOutput("sat_cnt", 32'(lock_loss_cnt), 32'd255);
`else
    checkOutput("sat_cnt", 32'(lock_loss_cnt), 32'd0);
`endif

    // Randomised episodes with enable and ratio changes along the way.
    for (int n = 0; n < 40; n++) begin
      en = 3'($urandom);
      d  = 12'($urandom);
      hi = $urandom_range(20, 70);
      lo = $urandom_range(1, 4);
      for (int c = 0; c < hi; c++) begin
        if ($urandom_range(0, 15) == 0) d = 12'($urandom);
        if ($urandom_range(0, 63) == 0) en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
        applyStimulus(1'b1, en, d);
      end
      for (int c = 0; c < lo; c++) applyStimulus(1'b0, en, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
